// File: rtl/load_store_unit_if.sv
// Core-request, response and data-memory signals of the load/store unit.
// master: the load/store unit itself; slave: the surrounding core and memory.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_addr, mem_wdata, mem_be, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_addr, mem_wdata, mem_be, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned byte-enabled memory beats,
// optional two-beat split of word-crossing accesses, load merge and extension.
module load_store_unit #(
  parameter int unsigned ADDR_W         = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [63:0]       raw_q;    // lanes of beat0 in [31:0], beat1 in [63:32]
  logic              fault_q;

  logic        req_fault;
  logic        cross_q;
  logic [7:0]  lane_mask;
  logic [63:0] wdata_wide;
  logic [31:0] load_word;
  logic [31:0] load_ext;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    unique case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
    logic [2:0] nbytes;
    unique case (sz)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    return ({1'b0, off} + nbytes) > 3'd4;
  endfunction

  function automatic logic illegal_op(input logic we, input logic [2:0] f3);
    return (f3[1:0] == 2'b11) || (we && f3[2]) || (!we && (f3 == 3'b110));
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  assign req_fault = illegal_op(bus.req_we, bus.req_funct3) ||
                     (!MISALIGN_SPLIT && crosses(bus.req_funct3[1:0], bus.req_addr[1:0]));
  assign cross_q   = crosses(funct3_q[1:0], addr_q[1:0]);
  // Low nibble enables beat0 lanes, high nibble the spill-over lanes of beat1.
  assign lane_mask  = {4'b0000, size_mask(funct3_q[1:0])} << addr_q[1:0];
  assign wdata_wide = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
  // Bytes in address order start at lane off of beat0.
  assign load_word  = 32'(raw_q >> {addr_q[1:0], 3'b000});

  // Sign- or zero-extend the assembled load bytes.
  always_comb begin
    unique case (funct3_q)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_ext = {24'h0, load_word[7:0]};
      3'b101:  load_ext = {16'h0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // State register, request capture and load-lane capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      raw_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.req_valid) begin
        addr_q   <= bus.req_addr;
        funct3_q <= bus.req_funct3;
        we_q     <= bus.req_we;
        wdata_q  <= bus.req_wdata;
        raw_q    <= '0;
        fault_q  <= req_fault;
      end
      if (state_q == StAcc0 && bus.mem_ready) begin
        raw_q[31:0] <= bus.mem_rdata & lane_bits(lane_mask[3:0]);
      end
      if (state_q == StAcc1 && bus.mem_ready) begin
        raw_q[63:32] <= bus.mem_rdata & lane_bits(lane_mask[7:4]);
      end
    end
  end

  // Next state and all outputs; outputs derive from registers so they hold during a stall.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_fault = 1'b0;
    bus.rsp_rdata = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = req_fault ? StResp : StAcc0;
        end
      end
      StAcc0: begin
        bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_be    = lane_mask[3:0];
        bus.mem_wdata = wdata_wide[31:0];
        bus.mem_read  = !we_q;
        bus.mem_write = we_q;
        if (bus.mem_ready) begin
          state_d = cross_q ? StAcc1 : StResp;
        end
      end
      StAcc1: begin
        bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
        bus.mem_be    = lane_mask[7:4];
        bus.mem_wdata = wdata_wide[63:32];
        bus.mem_read  = !we_q;
        bus.mem_write = we_q;
        if (bus.mem_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_fault = fault_q;
        bus.rsp_rdata = (fault_q || we_q) ? 32'h0 : load_ext;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
